sprite_cmd_queue: RTL and testbench

- Buffers sprite-draw commands (slot address, x, y, image code) issued by the processor's graphics write port (gmem_en strobe).
- Releases them to the VGA graphics engine only in the frame-end window, so sprite table updates are frame-atomic and never tear mid-scan.
- Sits between the processor's graphics outputs and the VGA graphics engine's gmem input.
- Runs on the processor clock.

---
 rtl/sprite_cmd_pkg.sv | 27 ++
 rtl/sprite_cmd_fifo.sv | 70 +++++++
 rtl/sprite_cmd_queue.sv | 147 ++++++++++++++
 tb/tb_sprite_cmd_queue.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_cmd_pkg
// Description : Shared types and default widths for the sprite command queue.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_cmd_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_X_W    = 8;
    localparam int DEF_Y_W    = 7;
    localparam int DEF_IMG_W  = 2;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_X_W-1:0]    x;
        logic [DEF_Y_W-1:0]    y;
        logic [DEF_IMG_W-1:0]  img;
    } sprite_cmd_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sprite_cmd_fifo
// Description : Single-clock FIFO of packed sprite commands with level count.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_cmd_fifo
    import sprite_cmd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = $bits(sprite_cmd_t)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    // Full is judged on registered level only, so a pop cannot make room
    // for a push in the same cycle.
    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : sprite_cmd_queue
// Description : Holds sprite-draw commands and releases them as one burst
//               after frame_end. Optional counters: SPRITE_CMD_QUEUE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_cmd_queue
    import sprite_cmd_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int X_W    = DEF_X_W,
    parameter int Y_W    = DEF_Y_W,
    parameter int IMG_W  = DEF_IMG_W
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [X_W-1:0]         wr_x,
    input  logic [Y_W-1:0]         wr_y,
    input  logic [IMG_W-1:0]       wr_img,
    output logic                   full,
    input  logic                   frame_end,
    output logic                   out_en,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [X_W-1:0]         out_x,
    output logic [Y_W-1:0]         out_y,
    output logic [IMG_W-1:0]       out_img,
    output logic [$clog2(DEPTH):0] level,
`ifdef SPRITE_CMD_QUEUE_STATS_EN
    output logic [15:0]            drop_count,
    output logic [15:0]            frames_drained,
`endif
    output logic                   overflow
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CMD_W = ADDR_W + X_W + Y_W + IMG_W;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LVL_W-1:0] r_remaining;
    logic [CMD_W-1:0] w_head;
    logic             w_empty;
    logic             w_load;
    logic             w_pop;

    sprite_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (wr_en),
        .i_data  ({wr_addr, wr_x, wr_y, wr_img}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (full),
        .o_empty (w_empty),
        .o_level (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (frame_end && !w_empty) w_state_nxt = DRAIN;
            DRAIN:   if (r_remaining <= LVL_W'(1)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The first pop happens on the frame_end edge itself, so the burst
    // starts the very next cycle; DRAIN pops the remaining K-1.
    always_comb begin
        w_load = 1'b0;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = frame_end && !w_empty;
                w_pop  = frame_end && !w_empty;
            end
            DRAIN:   w_pop = (r_remaining != '0);
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining <= '0;
        end else if (w_load) begin
            r_remaining <= level - LVL_W'(1);
        end else if (w_pop) begin
            r_remaining <= r_remaining - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_en   <= 1'b0;
            out_addr <= '0;
            out_x    <= '0;
            out_y    <= '0;
            out_img  <= '0;
        end else begin
            out_en <= w_pop;
            if (w_pop) begin
                {out_addr, out_x, out_y, out_img} <= w_head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

`ifdef SPRITE_CMD_QUEUE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count     <= '0;
            frames_drained <= '0;
        end else begin
            if (wr_en && full && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            if (w_load) begin
                frames_drained <= frames_drained + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_cmd_queue
// Description : Directed self-checking bench for sprite_cmd_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_cmd_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [1:0]  wr_img;
    logic        full;
    logic        frame_end;
    logic        out_en;
    logic [4:0]  out_addr;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [1:0]  out_img;
    logic [4:0]  level;
    logic        overflow;
`ifdef SPRITE_CMD_QUEUE_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] frames_drained;
`endif

    int cmp_count = 0;
    int err_count = 0;

    sprite_cmd_queue #(
        .DEPTH  (16),
        .ADDR_W (5),
        .X_W    (8),
        .Y_W    (7),
        .IMG_W  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_x           (wr_x),
        .wr_y           (wr_y),
        .wr_img         (wr_img),
        .full           (full),
        .frame_end      (frame_end),
        .out_en         (out_en),
        .out_addr       (out_addr),
        .out_x          (out_x),
        .out_y          (out_y),
        .out_img        (out_img),
        .level          (level),
`ifdef SPRITE_CMD_QUEUE_STATS_EN
        .drop_count     (drop_count),
        .frames_drained (frames_drained),
`endif
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
    task automatic write_cmd(input logic [4:0] a, input logic [7:0] x,
                             input logic [6:0] y, input logic [1:0] img);
        wr_en = 1'b1; wr_addr = a; wr_x = x; wr_y = y; wr_img = img;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] obs;
        reset = 1'b1; wr_en = 1'b0; frame_end = 1'b0;
        wr_addr = '0; wr_x = '0; wr_y = '0; wr_img = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        obs = {out_en, out_addr, out_x, out_y, out_img};
        cmp_count++;
        if (obs !== 23'h0) begin
            err_count++; $display("FAIL reset_outputs: got %h expected %h", obs, 23'h0);
        end
        cmp_count++;
        if ({level, full, overflow} !== 7'h0) begin
            err_count++; $display("FAIL reset_status: got %h expected %h", {level, full, overflow}, 7'h0);
        end
    endtask

    task automatic test_basic_drain();
        logic [22:0] obs;
        logic [22:0] exp_b [4];
        exp_b[0] = {1'b1, 5'd1, 8'd10, 7'd5, 2'd0};
        exp_b[1] = {1'b1, 5'd2, 8'd20, 7'd6, 2'd1};
        exp_b[2] = {1'b1, 5'd3, 8'd30, 7'd7, 2'd2};
        exp_b[3] = {1'b0, 5'd3, 8'd30, 7'd7, 2'd2};
        write_cmd(5'd1, 8'd10, 7'd5, 2'd0);
        write_cmd(5'd2, 8'd20, 7'd6, 2'd1);
        write_cmd(5'd3, 8'd30, 7'd7, 2'd2);
        @(negedge clk);
        cmp_count++;
        if (level !== 5'd3) begin
            err_count++; $display("FAIL basic_level_before: got %0d expected 3", level);
        end
        @(posedge clk); #1;
        pulse_frame_end();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs = {out_en, out_addr, out_x, out_y, out_img};
            cmp_count++;
            if (obs !== exp_b[i]) begin
                err_count++; $display("FAIL basic_beat%0d: got %h expected %h", i, obs, exp_b[i]);
            end
        end
        cmp_count++;
        if (level !== 5'd0) begin
            err_count++; $display("FAIL basic_level_after: got %0d expected 0", level);
        end
    endtask

    task automatic test_empty_frame();
        logic [22:0] obs;
        logic [22:0] exp_b [2];
        exp_b[0] = {1'b1, 5'd17, 8'd40, 7'd9, 2'd3};
        exp_b[1] = {1'b0, 5'd17, 8'd40, 7'd9, 2'd3};
        @(posedge clk); #1;
        pulse_frame_end();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {out_en, out_addr, out_x, out_y, out_img};
            cmp_count++;
            if (obs !== {1'b0, 5'd3, 8'd30, 7'd7, 2'd2}) begin
                err_count++; $display("FAIL empty_idle%0d: got %h expected %h", i, obs, {1'b0, 5'd3, 8'd30, 7'd7, 2'd2});
            end
        end
        @(posedge clk); #1;
        write_cmd(5'd17, 8'd40, 7'd9, 2'd3);
        pulse_frame_end();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            obs = {out_en, out_addr, out_x, out_y, out_img};
            cmp_count++;
            if (obs !== exp_b[i]) begin
                err_count++; $display("FAIL empty_single%0d: got %h expected %h", i, obs, exp_b[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [22:0] obs;
        logic [22:0] exp;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            write_cmd(5'(i), 8'(i * 2), 7'(i + 1), 2'(i));
        end
        @(negedge clk);
        cmp_count++;
        if ({level, full, overflow} !== {5'd16, 1'b1, 1'b0}) begin
            err_count++; $display("FAIL ovf_full: got %h expected %h", {level, full, overflow}, {5'd16, 1'b1, 1'b0});
        end
        write_cmd(5'd31, 8'd99, 7'd99, 2'd3);
        @(negedge clk);
        cmp_count++;
        if ({level, full, overflow} !== {5'd16, 1'b1, 1'b1}) begin
            err_count++; $display("FAIL ovf_drop: got %h expected %h", {level, full, overflow}, {5'd16, 1'b1, 1'b1});
        end
`ifdef SPRITE_CMD_QUEUE_STATS_EN
        cmp_count++;
        if (drop_count !== 16'd1) begin
            err_count++; $display("FAIL ovf_drop_count: got %0d expected 1", drop_count);
        end
`endif
        @(posedge clk); #1;
        pulse_frame_end();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            obs = {out_en, out_addr, out_x, out_y, out_img};
            exp = (i < 16) ? {1'b1, 5'(i), 8'(i * 2), 7'(i + 1), 2'(i)}
                           : {1'b0, 5'd15, 8'd30, 7'd16, 2'd3};
            cmp_count++;
            if (obs !== exp) begin
                err_count++; $display("FAIL ovf_beat%0d: got %h expected %h", i, obs, exp);
            end
        end
        cmp_count++;
        if ({level, full, overflow} !== {5'd0, 1'b0, 1'b1}) begin
            err_count++; $display("FAIL ovf_after: got %h expected %h", {level, full, overflow}, {5'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [22:0] obs;
        @(posedge clk); #1;
        for (int i = 8; i < 13; i++) begin
            write_cmd(5'(i), 8'(i * 4), 7'(i), 2'(i));
        end
        pulse_frame_end();
        for (int i = 8; i < 10; i++) begin
            @(negedge clk);
            obs = {out_en, out_addr, out_x, out_y, out_img};
            cmp_count++;
            if (obs !== {1'b1, 5'(i), 8'(i * 4), 7'(i), 2'(i)}) begin
                err_count++; $display("FAIL rstmid_beat%0d: got %h expected %h", i, obs, {1'b1, 5'(i), 8'(i * 4), 7'(i), 2'(i)});
            end
        end
        reset = 1'b1;
        @(negedge clk);
        obs = {out_en, out_addr, out_x, out_y, out_img};
        cmp_count++;
        if (obs !== 23'h0) begin
            err_count++; $display("FAIL rstmid_outputs: got %h expected %h", obs, 23'h0);
        end
        cmp_count++;
        if ({level, full, overflow} !== 7'h0) begin
            err_count++; $display("FAIL rstmid_status: got %h expected %h", {level, full, overflow}, 7'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        pulse_frame_end();
        @(negedge clk);
        cmp_count++;
        if (out_en !== 1'b0) begin
            err_count++; $display("FAIL rstmid_discard: got %b expected 0", out_en);
        end
    endtask

    task automatic test_write_during_drain();
        logic [22:0] obs;
        logic [22:0] exp_b [8];
        exp_b[0] = {1'b1, 5'd4, 8'd20, 7'd6, 2'd0};
        exp_b[1] = {1'b1, 5'd5, 8'd25, 7'd7, 2'd1};
        exp_b[2] = {1'b1, 5'd6, 8'd30, 7'd8, 2'd2};
        exp_b[3] = {1'b1, 5'd7, 8'd35, 7'd9, 2'd3};
        exp_b[4] = {1'b0, 5'd7, 8'd35, 7'd9, 2'd3};
        exp_b[5] = {1'b1, 5'd20, 8'd1, 7'd2, 2'd1};
        exp_b[6] = {1'b1, 5'd21, 8'd3, 7'd4, 2'd2};
        exp_b[7] = {1'b0, 5'd21, 8'd3, 7'd4, 2'd2};
        @(posedge clk); #1;
        for (int i = 4; i < 8; i++) begin
            write_cmd(5'(i), 8'(i * 5), 7'(i + 2), 2'(i));
        end
        pulse_frame_end();
        wr_en = 1'b1; wr_addr = 5'd20; wr_x = 8'd1; wr_y = 7'd2; wr_img = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            obs = {out_en, out_addr, out_x, out_y, out_img};
            cmp_count++;
            if (obs !== exp_b[i]) begin
                err_count++; $display("FAIL wdd_beat%0d: got %h expected %h", i, obs, exp_b[i]);
            end
            @(posedge clk); #1;
            if (i == 0) begin
                wr_addr = 5'd21; wr_x = 8'd3; wr_y = 7'd4; wr_img = 2'd2;
            end else begin
                wr_en = 1'b0;
            end
        end
        @(negedge clk);
        cmp_count++;
        if (level !== 5'd2) begin
            err_count++; $display("FAIL wdd_level: got %0d expected 2", level);
        end
        @(posedge clk); #1;
        pulse_frame_end();
        for (int i = 5; i < 8; i++) begin
            @(negedge clk);
            obs = {out_en, out_addr, out_x, out_y, out_img};
            cmp_count++;
            if (obs !== exp_b[i]) begin
                err_count++; $display("FAIL wdd_beat%0d: got %h expected %h", i, obs, exp_b[i]);
            end
        end
    endtask

    task automatic test_write_with_frame_end();
        logic [22:0] obs;
        logic [22:0] exp_b [5];
        exp_b[0] = {1'b1, 5'd13, 8'd13, 7'd13, 2'd1};
        exp_b[1] = {1'b1, 5'd14, 8'd14, 7'd14, 2'd2};
        exp_b[2] = {1'b0, 5'd14, 8'd14, 7'd14, 2'd2};
        exp_b[3] = {1'b1, 5'd15, 8'd15, 7'd15, 2'd3};
        exp_b[4] = {1'b0, 5'd15, 8'd15, 7'd15, 2'd3};
        @(posedge clk); #1;
        write_cmd(5'd13, 8'd13, 7'd13, 2'd1);
        write_cmd(5'd14, 8'd14, 7'd14, 2'd2);
        wr_en = 1'b1; wr_addr = 5'd15; wr_x = 8'd15; wr_y = 7'd15; wr_img = 2'd3;
        frame_end = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; frame_end = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {out_en, out_addr, out_x, out_y, out_img};
            cmp_count++;
            if (obs !== exp_b[i]) begin
                err_count++; $display("FAIL wfe_beat%0d: got %h expected %h", i, obs, exp_b[i]);
            end
        end
        cmp_count++;
        if (level !== 5'd1) begin
            err_count++; $display("FAIL wfe_level: got %0d expected 1", level);
        end
        @(posedge clk); #1;
        pulse_frame_end();
        for (int i = 3; i < 5; i++) begin
            @(negedge clk);
            obs = {out_en, out_addr, out_x, out_y, out_img};
            cmp_count++;
            if (obs !== exp_b[i]) begin
                err_count++; $display("FAIL wfe_beat%0d: got %h expected %h", i, obs, exp_b[i]);
            end
        end
`ifdef SPRITE_CMD_QUEUE_STATS_EN
        cmp_count++;
        if (frames_drained !== 16'd4) begin
            err_count++; $display("FAIL stats_frames: got %0d expected 4", frames_drained);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_empty_frame();
        test_overflow();
        test_reset_mid_drain();
        test_write_during_drain();
        test_write_with_frame_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
`default_nettype wire
